// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: latches a result at start, counts down the
// busy window, then commits HI/LO. Also serves mfhi/mflo/mthi/mtlo and the D-stage stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_op,
  input  logic        E_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_use_MDU,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] E_MDU_result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic [7:0]  count;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_valid;

  logic        is_md, is_div, signed_op, a_neg, b_neg, res_neg;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag;
  logic [63:0] prod_mag, prod;
  logic [31:0] calc_hi, calc_lo;
  logic        calc_valid;

  // Signed ops work on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    is_md      = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU);
    is_div     = (E_MDU_op == OP_DIV) || (E_MDU_op == OP_DIVU);
    signed_op  = (E_MDU_op == OP_MULT) || (E_MDU_op == OP_DIV);
    a_neg      = signed_op & E_A[31];
    b_neg      = signed_op & E_B[31];
    res_neg    = a_neg ^ b_neg;
    a_mag      = a_neg ? (32'd0 - E_A) : E_A;
    b_mag      = b_neg ? (32'd0 - E_B) : E_B;
    prod_mag   = {32'd0, a_mag} * {32'd0, b_mag};
    prod       = res_neg ? (64'd0 - prod_mag) : prod_mag;
    div_b      = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / div_b;
    r_mag      = a_mag % div_b;
    calc_hi    = prod[63:32];
    calc_lo    = prod[31:0];
    calc_valid = 1'b1;
    if (is_div) begin
      calc_lo    = res_neg ? (32'd0 - q_mag) : q_mag;
      calc_hi    = a_neg ? (32'd0 - r_mag) : r_mag;
      calc_valid = (E_B != 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      count      <= 8'd0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (E_start && is_md) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            count      <= is_div ? DIV_LOAD : MULT_LOAD;
            pend_hi    <= calc_hi;
            pend_lo    <= calc_lo;
            pend_valid <= calc_valid;
          end else if (E_MDU_op == OP_MTHI) begin
            HI <= E_A;
          end else if (E_MDU_op == OP_MTLO) begin
            LO <= E_A;
          end
        end
        S_RUN: begin
          if (count == 8'd1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            count <= 8'd0;
            // A zero divisor leaves HI/LO untouched.
            if (pend_valid) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_req = D_use_MDU & (E_start | busy);

  always_comb begin
    E_MDU_result = 32'd0;
    if (E_MDU_op == OP_MFHI) E_MDU_result = HI;
    else if (E_MDU_op == OP_MFLO) E_MDU_result = LO;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit with sequencing controller for the P6 pipeline, placed in the E stage.
- Accepts mult/multu/div/divu starts and holds HI/LO; serves mfhi/mflo/mthi/mtlo.
- Models the multi-cycle busy window with a countdown counter and raises the stall request the hazard unit uses to freeze D.
- Its result feeds the GRF write-data selection path via the M/W pipeline registers, as the MDU-result source.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (>=1)
DIV_CYCLES, 10, busy cycles after a div/divu start (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
E_MDU_op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none
E_start  input  1  high for one cycle when a mult/multu/div/divu is in E
E_A  input  32  rs operand (forwarded)
E_B  input  32  rt operand (forwarded)
D_use_MDU  input  1  D-stage instruction is any MDU op (1..8)
busy  output  1  operation in progress
stall_req  output  1  request to freeze D/F and bubble E
E_MDU_result  output  32  mfhi -> HI, mflo -> LO, else 0 (combinational)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset is synchronous, active-high, and evaluated at the clk posedge.
- Reset clears: busy=0, counter=0, HI=0, LO=0, pending registers=0, state=IDLE.
- Reset mid-operation aborts the operation with no HI/LO commit.
- States: IDLE (busy=0) and RUN (busy=1). Counter width 8 bits.
- IDLE -> RUN: at the posedge where E_start=1 and E_MDU_op is 1..4.
  - Load counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
  - Compute and latch pending_hi/pending_lo from E_A/E_B at the same edge.
- RUN: counter decrements each posedge.
  - At the posedge where counter==1: copy pending to HI/LO, set busy=0, return to IDLE.
- Timing: start sampled at edge t; busy=1 for exactly N cycles; new HI/LO and busy=0 both visible after edge t+N.
- Arithmetic:
  - mult: signed 64-bit product. multu: unsigned 64-bit product. HI=[63:32], LO=[31:0].
  - div: signed, quotient truncates toward zero, remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - divu: unsigned division.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div/divu): still goes busy for DIV_CYCLES; HI/LO keep their old values at commit.
- mthi/mtlo: when E_MDU_op=7/8 and busy=0, HI/LO<=E_A at the next posedge. No busy.
  - If busy=1, the write is ignored. The stall prevents this case in normal operation.
- E_start while busy=1: ignored; no restart, counter unaffected.
- E_start with an op outside 1..4: ignored.
- mthi/mtlo in the same cycle a commit occurs: cannot co-occur, because the commit requires busy=1.
- stall_req = D_use_MDU & (E_start | busy). Combinational; no stall on the cycle busy has just fallen.
- mfhi/mflo in E reads the current HI/LO registers combinationally. A value committed at edge t+N is readable from cycle t+N+1 on.

Test Plan:
- Reset, then mult E_A=0xFFFFFFFE(-2), E_B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF*0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001. Held D_use_MDU=1 -> stall_req high during start cycle plus 5 busy cycles, then low.
- div -7/2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 after mthi 0x11 and mtlo 0x22 -> busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mtlo 0x1234 then mflo in the next cycle -> E_MDU_result=0x1234. mfhi with E_MDU_op=5 -> E_MDU_result=HI; op=0 -> result 0.
- Start div, assert reset at busy cycle 4 -> next cycle busy=0, HI=LO=0, no later commit. Also: second E_start during busy -> ignored, busy ends at the original cycle count.
- 0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0. D_use_MDU=0 while busy -> stall_req=0.
